// File: rtl/usb_uart_stream_engine.sv
// rtl/usb_uart_stream_engine.sv - echo / periodic-message stream engine owning the usb_uart byte port
module usb_uart_stream_engine #(
    parameter int                   MSG_LEN    = 13,
    parameter logic [MSG_LEN*8-1:0] MSG        = "Hello World!\n",
    parameter int                   DELAY_W    = 24,
    parameter int                   FIFO_DEPTH = 16,
    parameter bit                   UPCASE     = 1'b0
) (
    input  logic                        clk_48mhz,
    input  logic                        resetn,
    input  logic [1:0]                  mode,
    output logic                        uart_we,
    output logic                        uart_re,
    output logic [7:0]                  uart_di,
    input  logic [7:0]                  uart_do,
    input  logic                        uart_wait,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        msg_active,
    output logic [15:0]                 tx_count,
    output logic [15:0]                 rx_count
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]  MSG_END  = 8'(MSG_LEN);

    typedef enum logic [2:0] {ST_IDLE, ST_RD_REQ, ST_RD_CAP, ST_WR_REQ, ST_GAP} state_t;

    state_t             state;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [7:0]         msg_idx;
    logic               msg_due;
    logic               last_wr;
    logic [DELAY_W-1:0] ivl_cnt;
    logic               fifo_empty;
    logic               fifo_full;
    logic               msg_start;
    logic               wr_ok;
    logic               rd_ok;
    logic               do_wr;
    logic               push;

    function automatic logic [7:0] upcase(input logic [7:0] b);
        if (UPCASE && b >= 8'h61 && b <= 8'h7a) return b - 8'h20;
        return b;
    endfunction

    // byte 0 of MSG sits in the most significant byte
    function automatic logic [7:0] msg_byte(input logic [7:0] idx);
        logic [MSG_LEN*8-1:0] sh;
        sh = MSG << {idx, 3'b000};
        return sh[MSG_LEN*8-1 -: 8];
    endfunction

    always_comb begin
        fifo_empty = (fifo_level == '0);
        fifo_full  = (fifo_level == FULL_LVL);
        msg_start  = !msg_active && msg_due && mode[1];
        wr_ok      = msg_active || msg_start || (!fifo_empty && mode[0]);
        rd_ok      = mode[0] && !fifo_full;
        do_wr      = wr_ok && (!rd_ok || !last_wr);
        push       = (state == ST_RD_CAP) && !uart_wait;
    end

    always_ff @(posedge clk_48mhz) begin
        if (push) mem[wr_ptr] <= upcase(uart_do);
    end

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            uart_we    <= 1'b0;
            uart_re    <= 1'b0;
            uart_di    <= 8'h00;
            fifo_level <= '0;
            msg_active <= 1'b0;
            tx_count   <= 16'h0000;
            rx_count   <= 16'h0000;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            msg_idx    <= 8'h00;
            msg_due    <= 1'b0;
            last_wr    <= 1'b0;
            ivl_cnt    <= '0;
        end else begin
            ivl_cnt <= ivl_cnt + 1'b1;
            if (&ivl_cnt && !msg_active) msg_due <= 1'b1;
            if (!uart_wait) begin
                case (state)
                    ST_IDLE: begin
                        if (mode == 2'b00) begin
                            wr_ptr     <= '0;
                            rd_ptr     <= '0;
                            fifo_level <= '0;
                            msg_due    <= 1'b0;
                            msg_active <= 1'b0;
                        end else begin
                            if (!mode[1]) msg_due <= 1'b0;
                            if (do_wr) begin
                                uart_we <= 1'b1;
                                last_wr <= 1'b1;
                                state   <= ST_WR_REQ;
                                if (msg_active) begin
                                    uart_di <= msg_byte(msg_idx);
                                    msg_idx <= msg_idx + 8'd1;
                                end else if (msg_start) begin
                                    uart_di    <= msg_byte(8'd0);
                                    msg_idx    <= 8'd1;
                                    msg_active <= 1'b1;
                                    msg_due    <= 1'b0;
                                end else begin
                                    uart_di    <= mem[rd_ptr];
                                    rd_ptr     <= rd_ptr + 1'b1;
                                    fifo_level <= fifo_level - 1'b1;
                                end
                            end else if (rd_ok) begin
                                uart_re <= 1'b1;
                                last_wr <= 1'b0;
                                state   <= ST_RD_REQ;
                            end
                        end
                    end
                    ST_RD_REQ: begin
                        uart_re <= 1'b0;
                        state   <= ST_RD_CAP;
                    end
                    ST_RD_CAP: begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        fifo_level <= fifo_level + 1'b1;
                        rx_count   <= rx_count + 16'd1;
                        state      <= ST_GAP;
                    end
                    ST_WR_REQ: begin
                        uart_we  <= 1'b0;
                        tx_count <= tx_count + 16'd1;
                        if (msg_active && msg_idx == MSG_END) msg_active <= 1'b0;
                        state    <= ST_GAP;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_uart_stream_engine.sv
// tb/tb_usb_uart_stream_engine.sv - self-checking bench for usb_uart_stream_engine
module tb_usb_uart_stream_engine;
    localparam int                   MSG_LEN = 13;
    localparam logic [MSG_LEN*8-1:0] MSG     = "Hello World!\n";
    localparam int                   DW      = 6;
    localparam int                   DEPTH   = 4;
    localparam int                   NTV     = 10;

    logic        clk_48mhz = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        uart_we, uart_re;
    logic [7:0]  uart_di;
    logic [7:0]  uart_do = 8'h00;
    logic        uart_wait = 1'b0;
    logic [2:0]  fifo_level;
    logic        msg_active;
    logic [15:0] tx_count, rx_count;

    usb_uart_stream_engine #(.MSG_LEN(MSG_LEN), .MSG(MSG), .DELAY_W(DW), .FIFO_DEPTH(DEPTH), .UPCASE(1'b1)) dut (
        .clk_48mhz(clk_48mhz), .resetn(resetn), .mode(mode),
        .uart_we(uart_we), .uart_re(uart_re), .uart_di(uart_di), .uart_do(uart_do),
        .uart_wait(uart_wait), .fifo_level(fifo_level), .msg_active(msg_active),
        .tx_count(tx_count), .rx_count(rx_count));

    always #5 clk_48mhz = ~clk_48mhz;

    int n_chk = 0, n_fail = 0;
    task automatic chk_eq(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_up(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7a) ? b - 8'd32 : b;
    endfunction

    function automatic logic [7:0] ref_msg(input int k);
        logic [MSG_LEN*8-1:0] m;
        m = MSG;
        return m[(MSG_LEN-1-k)*8 +: 8];
    endfunction

    // usb_uart model + scoreboard state
    logic [7:0] src_q[$];
    logic [7:0] echo_q[$];
    int         starts[$];
    int         k, n_wr, n_rd, cyc, wait_pct;
    bit         chk_en, stall_empty, exp_msg_low, prev_acc, prev_req, prev_wait;
    logic [7:0] last_di;

    task automatic model_clear();
        src_q.delete(); echo_q.delete(); starts.delete();
        k = 0; n_wr = 0; n_rd = 0; cyc = 0;
        exp_msg_low = 0; prev_acc = 0; prev_req = 0; prev_wait = 0;
    endtask

    always @(negedge clk_48mhz) begin
        bit w;
        logic [7:0] b, e;
        if (!chk_en) begin
            uart_wait = 1'b0;
        end else begin
            cyc++;
            chk_eq("req_exclusive", int'(uart_we && uart_re), 0);
            if (prev_acc) chk_eq("idle_after_req", int'(uart_we || uart_re), 0);
            if ((uart_we || uart_re) && !prev_req) chk_eq("issue_without_wait", int'(prev_wait), 0);
            if (exp_msg_low) begin
                chk_eq("msg_active_fall", int'(msg_active), 0);
                exp_msg_low = 1'b0;
            end
            w = (int'($urandom_range(99)) < wait_pct);
            if (uart_re && stall_empty && src_q.size() == 0) w = 1'b1;
            uart_wait = w;
            prev_acc  = (uart_we || uart_re) && !w;
            prev_req  = uart_we || uart_re;
            prev_wait = w;
            if (uart_re && !w) begin
                b = (src_q.size() > 0) ? src_q.pop_front() : 8'($urandom);
                uart_do = b;
                chk_eq("no_read_when_full", int'(echo_q.size() < DEPTH), 1);
                echo_q.push_back(ref_up(b));
                n_rd++;
            end
            if (uart_we && !w) begin
                last_di = uart_di;
                if (k != 0) begin
                    chk_eq("msg_active_hold", int'(msg_active), 1);
                    chk_eq("msg_byte", int'(uart_di), int'(ref_msg(k)));
                    k++;
                end else if (msg_active) begin
                    starts.push_back(cyc);
                    chk_eq("msg_first_byte", int'(uart_di), int'(ref_msg(0)));
                    k = 1;
                end else if (echo_q.size() == 0) begin
                    chk_eq("echo_unexpected", int'(uart_di), -1);
                end else begin
                    e = echo_q.pop_front();
                    chk_eq("echo_byte", int'(uart_di), int'(e));
                end
                if (k == MSG_LEN) begin
                    k = 0;
                    exp_msg_low = 1'b1;
                end
                n_wr++;
            end
        end
    end

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;
    vec_t tv[NTV];

    task automatic do_reset(input logic [1:0] m);
        chk_en = 0;
        resetn = 1'b0;
        mode   = m;
        repeat (3) @(negedge clk_48mhz);
        model_clear();
        resetn = 1'b1;
        chk_en = 1;
    endtask

    initial begin
        int n, base;
        tv[0] = '{8'h41, 8'h41}; tv[1] = '{8'h62, 8'h42}; tv[2] = '{8'h61, 8'h41};
        tv[3] = '{8'h5A, 8'h5A}; tv[4] = '{8'h7B, 8'h7B}; tv[5] = '{8'h7A, 8'h5A};
        tv[6] = '{8'h60, 8'h60}; tv[7] = '{8'h40, 8'h40}; tv[8] = '{8'hE1, 8'hE1};
        tv[9] = '{8'h30, 8'h30};
        chk_en = 0; stall_empty = 0; wait_pct = 0;
        model_clear();

        // reset values
        repeat (3) @(negedge clk_48mhz);
        chk_eq("rst_we", int'(uart_we), 0);
        chk_eq("rst_re", int'(uart_re), 0);
        chk_eq("rst_di", int'(uart_di), 0);
        chk_eq("rst_level", int'(fifo_level), 0);
        chk_eq("rst_msg_active", int'(msg_active), 0);
        chk_eq("rst_tx", int'(tx_count), 0);
        chk_eq("rst_rx", int'(rx_count), 0);

        // periodic message: first write about one interval after reset, then every 2**DW cycles
        do_reset(2'b10);
        n = 0;
        while (!uart_we && n < 200) begin @(negedge clk_48mhz); n++; end
        chk_eq("first_msg_latency", int'(n >= (1 << DW) - 1 && n <= (1 << DW) + 3), 1);
        n = 0;
        while (starts.size() < 2 && n < 400) begin @(negedge clk_48mhz); n++; end
        chk_eq("msg_start_timeout", int'(starts.size() >= 2), 1);
        if (starts.size() >= 2) chk_eq("msg_period", starts[1] - starts[0], 1 << DW);

        // echo with UPCASE, one byte at a time
        do_reset(2'b00);
        stall_empty = 1;
        mode = 2'b01;
        for (int i = 0; i < NTV; i++) begin
            src_q.push_back(tv[i].din);
            base = n_wr;
            n = 0;
            while (n_wr == base && n < 60) begin @(negedge clk_48mhz); n++; end
            chk_eq("echo_timeout", int'(n < 60), 1);
            chk_eq("echo_vector", int'(last_di), int'(tv[i].dout));
        end
        repeat (4) @(negedge clk_48mhz);
        chk_eq("echo_tx_count", int'(tx_count), NTV);
        chk_eq("echo_rx_count", int'(rx_count), NTV);
        chk_eq("echo_level", int'(fifo_level), 0);

        // FIFO fills while a message owns the write side; clearing bit0 holds the bytes
        stall_empty = 0;
        mode = 2'b11;
        n = 0;
        while (fifo_level != 3'(DEPTH) && n < 400) begin @(negedge clk_48mhz); n++; end
        chk_eq("fifo_full_reached", int'(fifo_level), DEPTH);
        mode = 2'b10;
        n = 0;
        while (msg_active && n < 200) begin @(negedge clk_48mhz); n++; end
        repeat (3) @(negedge clk_48mhz);
        chk_eq("held_level", int'(fifo_level), DEPTH);
        chk_eq("held_level_model", int'(fifo_level), echo_q.size());

        // drain with wait pulses, then randomized mode mix
        mode = 2'b01;
        wait_pct = 30;
        repeat (150) @(negedge clk_48mhz);
        wait_pct = 25;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) mode = 2'($urandom_range(1, 3));
            @(negedge clk_48mhz);
        end
        mode = 2'b00;
        repeat (20) @(negedge clk_48mhz);
        chk_eq("rand_tx_count", int'(tx_count), n_wr & 16'hFFFF);
        chk_eq("rand_rx_count", int'(rx_count), n_rd & 16'hFFFF);
        chk_eq("flush_level", int'(fifo_level), 0);
        chk_eq("flush_msg_active", int'(msg_active), 0);
        echo_q.delete();
        k = 0;

        // mode=0 mid-message aborts
        wait_pct = 0;
        mode = 2'b10;
        n = 0;
        while (!msg_active && n < 200) begin @(negedge clk_48mhz); n++; end
        base = n_wr;
        n = 0;
        while (n_wr < base + 3 && n < 50) begin @(negedge clk_48mhz); n++; end
        mode = 2'b00;
        base = n_wr;
        repeat (10) @(negedge clk_48mhz);
        chk_eq("abort_msg_active", int'(msg_active), 0);
        chk_eq("abort_writes", int'(n_wr - base <= 1), 1);
        k = 0;
        exp_msg_low = 0;

        // asynchronous reset while a write request is up
        mode = 2'b11;
        n = 0;
        while (!uart_we && n < 300) begin @(negedge clk_48mhz); n++; end
        chk_eq("wr_req_seen", int'(uart_we), 1);
        #2;
        chk_en = 0;
        resetn = 1'b0;
        #1;
        chk_eq("async_we", int'(uart_we), 0);
        chk_eq("async_msg_active", int'(msg_active), 0);
        chk_eq("async_tx", int'(tx_count), 0);
        chk_eq("async_level", int'(fifo_level), 0);
        do_reset(2'b01);
        repeat (60) @(negedge clk_48mhz);
        mode = 2'b00;
        repeat (10) @(negedge clk_48mhz);
        chk_eq("post_reset_tx", int'(tx_count), n_wr);
        chk_eq("post_reset_rx", int'(rx_count), n_rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
